ibex_obi_sram_responder: RTL and testbench
==========================================

// Module: ibex_obi_sram_responder
// PURPOSE
// - OBI-style memory responder: drives core instr_*/data_* fetch and load/store port from a 1-port SRAM macro.
// - Sits directly upstream of the core instr_*/data_* inputs; one instance per port.
// - Adds programmable grant wait and response latency, limits outstanding requests.
// - Flags out-of-range accesses as bus errors.
// PARAMETERS
// - AddrBase        32'h0010_0000  byte base of the mapped window
// - MemSizeBytes    65536          window size; power of two, >= 4
// - ReadLatency     1              cycles from gnt_o to rvalid_o; >= 1
// - MaxOutstanding  2              max granted-but-unanswered requests; >= 1
// - GntWaitCycles   0              cycles req_i must be held high before gnt_o; 0 = same-cycle grant
// PORTS
// - clk_i          in   1   clock
// - rst_ni         in   1   async active-low reset
// - req_i          in   1   request from core
// - gnt_o          out  1   request accepted this cycle
// - addr_i         in   32  byte address (word-aligned by core)
// - we_i           in   1   1 = write
// - be_i           in   4   byte enables
// - wdata_i        in   32  write data
// - rvalid_o       out  1   response valid (single cycle, no backpressure)
// - rdata_o        out  32  read data; 0 for writes, errors, idle cycles
// - rdata_intg_o   out  7   prim_secded_inv_39_32_enc check bits of rdata_o
// - err_o          out  1   bus error, qualified by rvalid_o
// - mem_req_o      out  1   SRAM access strobe
// - mem_we_o       out  1   SRAM write
// - mem_addr_o     out  AW  word index, AW = $clog2(MemSizeBytes)-2
// - mem_wdata_o    out  32  SRAM write data
// - mem_wmask_o    out  32  bit mask, each be_i bit replicated x8
// - mem_rdata_i    in   32  SRAM read data, valid 1 cycle after mem_req_o
// BEHAVIOUR
// - Reset: gnt_o, rvalid_o, err_o, mem_req_o, rdata_o = 0; counters and pipeline cleared.
//   Async assert discards in-flight responses; no rvalid_o for them after release.
// - Wait counter:
//   - Counts cycles with req_i=1 and no grant.
//   - Clears on gnt_o and on any cycle with req_i=0 (protocol violation tolerated).
// - Grant: gnt_o = req_i & (wait_cnt == GntWaitCycles) & (outst < MaxOutstanding | retire).
//   - retire = rvalid_o this cycle.
//   - Combinational from req_i and state.
// - In range: (addr_i - AddrBase) < MemSizeBytes, unsigned 32-bit compare.
// - SRAM access on grant:
//   - Granted in-range request: mem_req_o = 1 in the gnt cycle.
//   - mem_addr_o = (addr_i - AddrBase) >> 2.
//   - mem_we_o = we_i; mem_wdata_o = wdata_i; mem_wmask_o from be_i.
// - Out-of-range grant: mem_req_o stays 0; response has err_o=1, rdata_o=0.
// - Response pipeline: L = ReadLatency stages of {valid, we, err}, shifted every cycle.
//   - rvalid_o asserted exactly L cycles after the gnt cycle; strictly in order; one per grant.
//   - L == 1: rdata_o = mem_rdata_i when valid & !we & !err, else 0 (combinational pass-through).
//   - L > 1: mem_rdata_i captured in stage 1, carried through registered stages.
// - Outstanding counter outst (width $clog2(MaxOutstanding+1)):
//   - +1 on gnt_o, -1 on rvalid_o; unchanged when both occur.
//   - Never exceeds MaxOutstanding, never underflows.
// - Back-to-back: grants every cycle permitted when GntWaitCycles=0 and MaxOutstanding >= L.
// - Writes: rvalid_o with rdata_o=0, err_o=0; SRAM written in the gnt cycle.
// - rdata_intg_o always the encoding of the current rdata_o, including 0 when idle.
// TESTING
// - Reset, L=1, wait=0: read 0x0010_0004 with SRAM word1=0xDEADBEEF
//   -> gnt same cycle, mem_addr_o=1, next-cycle rvalid, rdata 0xDEADBEEF, err 0.
// - Write 0x0010_0008, be=4'b0101, wdata=0x11223344
//   -> mem_we_o=1, mem_wmask_o=0x00FF00FF, rvalid next cycle, rdata 0.
// - Read 0x0000_0000 (out of range)
//   -> mem_req_o stays 0, rvalid after L, err_o=1, rdata_o=0.
// - L=3, MaxOutstanding=2, req held high 6 cycles
//   -> grants at cycles 0,1; none at 2; grant at 3 together with first rvalid.
// - GntWaitCycles=2 -> gnt on 3rd cycle of held req; req dropped after 1 cycle -> wait counter clears.
// - rst_ni asserted one cycle after grant with L=3 -> no rvalid_o after release, outst=0.

Source files
------------

// File: rtl/ibex_obi_sram_responder.sv
// -----------------------------------------------------------------------------
// ibex_obi_sram_responder
//
// OBI-style memory responder that serves one Ibex fetch or load/store port
// from a single-port SRAM macro. One instance sits directly in front of the
// core's instr_* or data_* inputs.
//
// Features:
//   - programmable grant wait (req_i must be held GntWaitCycles cycles)
//   - fixed response latency of ReadLatency cycles after the grant
//   - limit of MaxOutstanding granted-but-unanswered requests
//   - out-of-window accesses answered with err_o and never reach the SRAM
//   - rdata_intg_o carries SECDED (inverted 39/32) check bits of rdata_o
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i/gnt_o          request handshake (gnt_o combinational)
//   addr_i, we_i, be_i,  request attributes
//   wdata_i
//   rvalid_o, rdata_o,   single-cycle response, no backpressure
//   rdata_intg_o, err_o
//   mem_req_o, mem_we_o, SRAM macro port; mem_rdata_i is valid one cycle
//   mem_addr_o,          after mem_req_o
//   mem_wdata_o,
//   mem_wmask_o,
//   mem_rdata_i
// -----------------------------------------------------------------------------
module ibex_obi_sram_responder #(
  parameter logic [31:0] AddrBase       = 32'h0010_0000,
  parameter int unsigned MemSizeBytes   = 65536,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned GntWaitCycles  = 0,
  localparam int unsigned AW            = $clog2(MemSizeBytes) - 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  input  logic          req_i,
  output logic          gnt_o,
  input  logic [31:0]   addr_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,

  output logic          rvalid_o,
  output logic [31:0]   rdata_o,
  output logic [6:0]    rdata_intg_o,
  output logic          err_o,

  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [31:0]   mem_wmask_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned WaitW = (GntWaitCycles > 0) ? $clog2(GntWaitCycles + 1) : 1;

  // ---------------------------------------------------------------------------
  // SECDED inverted 39/32 encoder, check bits only. The inversion constant
  // makes an all-zero word carry non-zero check bits, so a stuck-at-zero bus
  // is detectable.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] secded_inv_39_32_chk(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606_BD25);
    c[1] = ^(d & 32'hDEBA_8050);
    c[2] = ^(d & 32'h413D_89AA);
    c[3] = ^(d & 32'h3123_4ED1);
    c[4] = ^(d & 32'hC2C1_323B);
    c[5] = ^(d & 32'h2DCC_624C);
    c[6] = ^(d & 32'h9850_5586);
    return c ^ 7'h2A;
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode. The subtraction wraps, so addresses below AddrBase become
  // huge offsets and fail the single unsigned compare.
  // ---------------------------------------------------------------------------
  logic [31:0] offset;
  logic        in_range;

  assign offset   = addr_i - AddrBase;
  assign in_range = (offset < MemSizeBytes);

  // ---------------------------------------------------------------------------
  // Grant wait counter and outstanding counter
  // ---------------------------------------------------------------------------
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [OutW-1:0]  outst_q, outst_d;
  logic             wait_done;
  logic             room;
  logic             retire;

  assign wait_done = (wait_cnt_q == WaitW'(GntWaitCycles));
  assign room      = (outst_q < OutW'(MaxOutstanding)) | retire;
  assign gnt_o     = req_i & wait_done & room;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!req_i || gnt_o) begin
      wait_cnt_d = '0;
    end else if (!wait_done) begin
      // Saturates at GntWaitCycles while a grant is blocked by outst.
      wait_cnt_d = wait_cnt_q + WaitW'(1);
    end
  end

  always_comb begin
    outst_d = outst_q;
    unique case ({gnt_o, retire})
      2'b10:   outst_d = outst_q + OutW'(1);
      2'b01:   outst_d = outst_q - OutW'(1);
      default: outst_d = outst_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values of the others, independent of
  // evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
      outst_q    <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      outst_q    <= outst_d;
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM access in the grant cycle. Out-of-range grants never strobe the
  // macro; mem_we_o is qualified so the macro never sees a stray write.
  // ---------------------------------------------------------------------------
  assign mem_req_o   = gnt_o & in_range;
  assign mem_we_o    = mem_req_o & we_i;
  assign mem_addr_o  = offset[AW+1:2];
  assign mem_wdata_o = wdata_i;
  assign mem_wmask_o = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

  // ---------------------------------------------------------------------------
  // Response pipeline: stage i holds the attributes of the grant issued i+1
  // cycles ago; the last stage is the response presented to the core.
  // ---------------------------------------------------------------------------
  logic [ReadLatency-1:0] vld_q;
  logic [ReadLatency-1:0] we_q;
  logic [ReadLatency-1:0] err_q;

  // NOTE: the pipeline is reset (not left to power-up values) because an
  // asynchronous reset must discard in-flight responses; a stale valid bit
  // would otherwise produce an rvalid_o after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      we_q  <= '0;
      err_q <= '0;
    end else begin
      vld_q[0] <= gnt_o;
      we_q[0]  <= we_i;
      err_q[0] <= ~in_range;
      for (int i = 1; i < ReadLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        we_q[i]  <= we_q[i-1];
        err_q[i] <= err_q[i-1];
      end
    end
  end

  assign retire   = vld_q[ReadLatency-1];
  assign rvalid_o = retire;
  assign err_o    = vld_q[ReadLatency-1] & err_q[ReadLatency-1];

  // ---------------------------------------------------------------------------
  // Read data path. With a single-cycle latency the SRAM output is forwarded
  // combinationally; otherwise it is captured when stage 0 is a valid read
  // (the cycle mem_rdata_i is valid) and carried alongside the valid bits.
  // Anything that is not a successful read carries zero.
  // ---------------------------------------------------------------------------
  if (ReadLatency == 1) begin : g_rdata_pass
    assign rdata_o = (vld_q[0] & ~we_q[0] & ~err_q[0]) ? mem_rdata_i : 32'h0;
  end else begin : g_rdata_pipe
    // rdata_q[i] lines up with pipeline stage i+1.
    logic [31:0] rdata_q [ReadLatency-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < ReadLatency - 1; i++) begin
          rdata_q[i] <= 32'h0;
        end
      end else begin
        rdata_q[0] <= (vld_q[0] & ~we_q[0] & ~err_q[0]) ? mem_rdata_i : 32'h0;
        for (int i = 1; i < ReadLatency - 1; i++) begin
          rdata_q[i] <= rdata_q[i-1];
        end
      end
    end

    assign rdata_o = rdata_q[ReadLatency-2];
  end

  assign rdata_intg_o = secded_inv_39_32_chk(rdata_o);

endmodule

// File: tb/tb_ibex_obi_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_ibex_obi_sram_responder
//
// Three responder instances with different configurations share one clock,
// one reset and the request attribute bus; each has its own req and its own
// SRAM model:
//   u_a : ReadLatency=1, MaxOutstanding=2, GntWaitCycles=0
//   u_b : ReadLatency=3, MaxOutstanding=2, GntWaitCycles=0
//   u_c : ReadLatency=1, MaxOutstanding=2, GntWaitCycles=2
// Expected responses are queued when a grant is seen and popped when the
// instance raises rvalid; each entry records the cycle it must appear in.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ibex_obi_sram_responder;

  typedef struct packed {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_a, req_b, req_c;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic        gnt_a, rvalid_a, err_a, mem_req_a, mem_we_a;
  logic [31:0] rdata_a, mem_wdata_a, mem_wmask_a, mem_rdata_a;
  logic [6:0]  intg_a;
  logic [13:0] mem_addr_a;

  logic        gnt_b, rvalid_b, err_b, mem_req_b, mem_we_b;
  logic [31:0] rdata_b, mem_wdata_b, mem_wmask_b, mem_rdata_b;
  logic [6:0]  intg_b;
  logic [13:0] mem_addr_b;

  logic        gnt_c, rvalid_c, err_c, mem_req_c, mem_we_c;
  logic [31:0] rdata_c, mem_wdata_c, mem_wmask_c, mem_rdata_c;
  logic [6:0]  intg_c;
  logic [13:0] mem_addr_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ibex_obi_sram_responder #(.ReadLatency(1), .MaxOutstanding(2), .GntWaitCycles(0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .rdata_intg_o(intg_a),
    .err_o(err_a), .mem_req_o(mem_req_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a),
    .mem_wdata_o(mem_wdata_a), .mem_wmask_o(mem_wmask_a), .mem_rdata_i(mem_rdata_a)
  );

  ibex_obi_sram_responder #(.ReadLatency(3), .MaxOutstanding(2), .GntWaitCycles(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .rdata_intg_o(intg_b),
    .err_o(err_b), .mem_req_o(mem_req_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
    .mem_wdata_o(mem_wdata_b), .mem_wmask_o(mem_wmask_b), .mem_rdata_i(mem_rdata_b)
  );

  ibex_obi_sram_responder #(.ReadLatency(1), .MaxOutstanding(2), .GntWaitCycles(2)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_c), .gnt_o(gnt_c), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_c), .rdata_o(rdata_c), .rdata_intg_o(intg_c),
    .err_o(err_c), .mem_req_o(mem_req_c), .mem_we_o(mem_we_c), .mem_addr_o(mem_addr_c),
    .mem_wdata_o(mem_wdata_c), .mem_wmask_o(mem_wmask_c), .mem_rdata_i(mem_rdata_c)
  );

  // Behavioural single-port SRAMs: masked write, read data one cycle later.
  logic [31:0] sram_a [16384];
  logic [31:0] sram_b [16384];
  logic [31:0] sram_c [16384];

  always @(posedge clk) begin
    if (mem_req_a) begin
      if (mem_we_a) sram_a[mem_addr_a] <= (sram_a[mem_addr_a] & ~mem_wmask_a) | (mem_wdata_a & mem_wmask_a);
      else          mem_rdata_a <= sram_a[mem_addr_a];
    end
  end

  always @(posedge clk) begin
    if (mem_req_b) begin
      if (mem_we_b) sram_b[mem_addr_b] <= (sram_b[mem_addr_b] & ~mem_wmask_b) | (mem_wdata_b & mem_wmask_b);
      else          mem_rdata_b <= sram_b[mem_addr_b];
    end
  end

  always @(posedge clk) begin
    if (mem_req_c) begin
      if (mem_we_c) sram_c[mem_addr_c] <= (sram_c[mem_addr_c] & ~mem_wmask_c) | (mem_wdata_c & mem_wmask_c);
      else          mem_rdata_c <= sram_c[mem_addr_c];
    end
  end

  // Reference check-bit generator: parity of each masked data column,
  // then the fixed inversion pattern.
  function automatic logic [6:0] ecc7(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0]  r;
    m = '{32'h2606_BD25, 32'hDEBA_8050, 32'h413D_89AA, 32'h3123_4ED1,
          32'hC2C1_323B, 32'h2DCC_624C, 32'h9850_5586};
    for (int i = 0; i < 7; i++) r[i] = ^(d & m[i]);
    return r ^ 7'b010_1010;
  endfunction

  // Sample on the falling edge and score every instance's response port.
  task automatic sample();
    logic        v, er;
    logic [31:0] d;
    logic [6:0]  ig;
    logic        have;
    exp_t        e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin v = rvalid_a; d = rdata_a; er = err_a; ig = intg_a; end
        1:       begin v = rvalid_b; d = rdata_b; er = err_b; ig = intg_b; end
        default: begin v = rvalid_c; d = rdata_c; er = err_c; ig = intg_c; end
      endcase
      if (v) begin
        have = 1'b0;
        e    = '0;
        case (i)
          0:       if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
          1:       if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
          default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
        endcase
        total++;
        if (!have) begin
          bad++;
          $display("FAIL unexpected_rvalid inst=%0d cyc=%0d rdata=%h err=%b", i, cyc, d, er);
        end else begin
          total++;
          if (cyc !== e.cyc || d !== e.rdata || er !== e.err || ig !== ecc7(e.rdata)) begin
            bad++;
            $display("FAIL response inst=%0d got cyc=%0d rdata=%h err=%b intg=%h want cyc=%0d rdata=%h err=%b intg=%h",
                     i, cyc, d, er, ig, e.cyc, e.rdata, e.err, ecc7(e.rdata));
          end
        end
      end else begin
        total++;
        if (d !== 32'h0 || er !== 1'b0 || ig !== ecc7(32'h0)) begin
          bad++;
          $display("FAIL idle_response inst=%0d cyc=%0d got rdata=%h err=%b intg=%h want 0/0/%h",
                   i, cyc, d, er, ig, ecc7(32'h0));
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      sample();
      advance();
    end
  endtask

  // One request on u_a (same-cycle grant expected); req_a left high so calls
  // chain back to back.
  task automatic a_access(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] d, input logic in_rng, input logic [13:0] idx,
                          input logic [31:0] mask, input logic [31:0] rd);
    exp_t e;
    req_a = 1'b1; addr = a; we = w; be = b; wdata = d;
    sample();
    total++;
    if (gnt_a !== 1'b1) begin
      bad++;
      $display("FAIL a_gnt addr=%h got %b want 1", a, gnt_a);
    end
    total++;
    if (mem_req_a !== in_rng) begin
      bad++;
      $display("FAIL a_mem_req addr=%h got %b want %b", a, mem_req_a, in_rng);
    end
    if (in_rng) begin
      total++;
      if (mem_addr_a !== idx || mem_we_a !== w || mem_wmask_a !== mask || mem_wdata_a !== d) begin
        bad++;
        $display("FAIL a_mem_port addr=%h got idx=%h we=%b mask=%h wdata=%h want idx=%h we=%b mask=%h wdata=%h",
                 a, mem_addr_a, mem_we_a, mem_wmask_a, mem_wdata_a, idx, w, mask, d);
      end
    end
    if (gnt_a === 1'b1) begin
      e.cyc = cyc + 1; e.rdata = rd; e.err = ~in_rng;
      q_a.push_back(e);
    end
    advance();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sample();
    total++;
    if ({gnt_a, rvalid_a, err_a, mem_req_a, gnt_b, rvalid_b, gnt_c, rvalid_c} !== 8'h00 || rdata_a !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs got gnt=%b%b%b rvalid=%b%b%b err=%b mem_req=%b rdata=%h want all 0",
               gnt_a, gnt_b, gnt_c, rvalid_a, rvalid_b, rvalid_c, err_a, mem_req_a, rdata_a);
    end
    advance();
    idle(1);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_read_write();
    a_access(32'h0010_0004, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, 14'd1, 32'hFFFF_FFFF, 32'h0);
    a_access(32'h0010_0008, 1'b1, 4'hF, 32'hAABB_CCDD, 1'b1, 14'd2, 32'hFFFF_FFFF, 32'h0);
    a_access(32'h0010_0008, 1'b1, 4'b0101, 32'h1122_3344, 1'b1, 14'd2, 32'h00FF_00FF, 32'h0);
    a_access(32'h0010_0004, 1'b0, 4'hF, 32'h0, 1'b1, 14'd1, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    a_access(32'h0010_0008, 1'b0, 4'hF, 32'h0, 1'b1, 14'd2, 32'hFFFF_FFFF, 32'hAA22_CC44);
    req_a = 1'b0;
    idle(2);
  endtask

  task automatic test_out_of_range();
    a_access(32'h0000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 14'd0, 32'hFFFF_FFFF, 32'h0);
    a_access(32'h0010_FFFC, 1'b1, 4'hF, 32'h5A5A_1234, 1'b1, 14'd16383, 32'hFFFF_FFFF, 32'h0);
    a_access(32'h0010_FFFC, 1'b0, 4'hF, 32'h0, 1'b1, 14'd16383, 32'hFFFF_FFFF, 32'h5A5A_1234);
    a_access(32'h0011_0000, 1'b0, 4'hF, 32'h0, 1'b0, 14'd0, 32'hFFFF_FFFF, 32'h0);
    a_access(32'h000F_FFFC, 1'b1, 4'hF, 32'h7777_7777, 1'b0, 14'd0, 32'hFFFF_FFFF, 32'h0);
    req_a = 1'b0;
    idle(2);
  endtask

  // L=3, two outstanding: held request is granted 1,1,0,1,1,0.
  task automatic test_outstanding();
    logic [5:0] pat;
    exp_t       e;
    pat = 6'b011011;
    req_b = 1'b1; addr = 32'h0010_0004; we = 1'b1; be = 4'hF; wdata = 32'hCAFE_F00D;
    sample();
    total++;
    if (gnt_b !== 1'b1 || mem_req_b !== 1'b1 || mem_addr_b !== 14'd1) begin
      bad++;
      $display("FAIL b_write_gnt got gnt=%b mem_req=%b idx=%h want 1/1/1", gnt_b, mem_req_b, mem_addr_b);
    end
    if (gnt_b === 1'b1) begin
      e.cyc = cyc + 3; e.rdata = 32'h0; e.err = 1'b0; q_b.push_back(e);
    end
    advance();
    req_b = 1'b0;
    idle(4);
    req_b = 1'b1; we = 1'b0; wdata = 32'h0;
    for (int k = 0; k < 6; k++) begin
      sample();
      total++;
      if (gnt_b !== pat[k]) begin
        bad++;
        $display("FAIL b_held_gnt k=%0d got %b want %b", k, gnt_b, pat[k]);
      end
      if (gnt_b === 1'b1) begin
        e.cyc = cyc + 3; e.rdata = 32'hCAFE_F00D; e.err = 1'b0; q_b.push_back(e);
      end
      advance();
    end
    req_b = 1'b0;
    idle(5);
  endtask

  // GntWaitCycles=2: grant on the 3rd held cycle; a dropped request restarts.
  task automatic test_wait();
    logic [2:0] pat;
    exp_t       e;
    pat = 3'b100;
    addr = 32'h0000_0000; we = 1'b0; be = 4'hF; wdata = 32'h0;
    for (int r = 0; r < 2; r++) begin
      req_c = 1'b1;
      for (int k = 0; k < 3; k++) begin
        sample();
        total++;
        if (gnt_c !== pat[k]) begin
          bad++;
          $display("FAIL c_wait_gnt round=%0d k=%0d got %b want %b", r, k, gnt_c, pat[k]);
        end
        if (gnt_c === 1'b1) begin
          e.cyc = cyc + 1; e.rdata = 32'h0; e.err = 1'b1; q_c.push_back(e);
        end
        advance();
      end
      req_c = 1'b0;
      idle(1);
      if (r == 0) begin
        req_c = 1'b1;
        sample();
        total++;
        if (gnt_c !== 1'b0) begin
          bad++;
          $display("FAIL c_short_req got gnt=%b want 0", gnt_c);
        end
        advance();
        req_c = 1'b0;
        idle(1);
      end
    end
    idle(1);
  endtask

  // Reset one cycle after a grant on u_b: the response must never appear.
  task automatic test_reset_inflight();
    logic [2:0] pat;
    exp_t       e;
    pat = 3'b011;
    req_b = 1'b1; addr = 32'h0010_0004; we = 1'b0; be = 4'hF; wdata = 32'h0;
    sample();
    total++;
    if (gnt_b !== 1'b1) begin
      bad++;
      $display("FAIL b_pre_reset_gnt got %b want 1", gnt_b);
    end
    advance();
    req_b = 1'b0;
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(5);
    total++;
    if (u_b.outst_q !== 2'd0) begin
      bad++;
      $display("FAIL b_outst_after_reset got %0d want 0", u_b.outst_q);
    end
    req_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      total++;
      if (gnt_b !== pat[k]) begin
        bad++;
        $display("FAIL b_post_reset_gnt k=%0d got %b want %b", k, gnt_b, pat[k]);
      end
      if (gnt_b === 1'b1) begin
        e.cyc = cyc + 3; e.rdata = 32'hCAFE_F00D; e.err = 1'b0; q_b.push_back(e);
      end
      advance();
    end
    req_b = 1'b0;
    idle(5);
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0;

    test_reset();
    test_read_write();
    test_out_of_range();
    test_outstanding();
    test_wait();
    test_reset_inflight();

    total++;
    if (q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) begin
      bad++;
      $display("FAIL missing_responses got pending a=%0d b=%0d c=%0d want 0/0/0",
               q_a.size(), q_b.size(), q_c.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
